// File: rtl/reaction_pkg.sv
// Shared types and helpers for the reaction timing engine: FSM state encoding,
// DIGITS-wide BCD helpers and maximal-length LFSR tap masks.
package reaction_pkg;

  localparam int unsigned MaxDigits = 6;
  localparam int unsigned MaxW      = 4 * MaxDigits;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StHit     = 2'd2,
    StTimeout = 2'd3
  } state_e;

  // All-nines pattern in the low 'digits' BCD digits, zero above.
  function automatic logic [MaxW-1:0] all_nines(input int unsigned digits);
    logic [MaxW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(MaxDigits); i++) begin
      if (i < int'(digits)) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // a < b as BCD numbers, most significant digit decides first.
  function automatic logic bcd_lt(input logic [MaxW-1:0] a, input logic [MaxW-1:0] b,
                                  input int unsigned digits);
    logic lt;
    logic done;
    lt   = 1'b0;
    done = 1'b0;
    for (int i = int'(MaxDigits) - 1; i >= 0; i--) begin
      if (!done && (i < int'(digits)) && (a[4*i +: 4] != b[4*i +: 4])) begin
        lt   = (a[4*i +: 4] < b[4*i +: 4]);
        done = 1'b1;
      end
    end
    return lt;
  endfunction

  // Fibonacci feedback masks (bit n-1 = tap n) for maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] t;
    case (width)
      3:       t = 32'h0006;
      4:       t = 32'h000C;
      5:       t = 32'h0014;
      6:       t = 32'h0030;
      7:       t = 32'h0060;
      8:       t = 32'h00B8;
      9:       t = 32'h0110;
      10:      t = 32'h0240;
      11:      t = 32'h0500;
      12:      t = 32'h0E08;
      13:      t = 32'h1C80;
      14:      t = 32'h3802;
      15:      t = 32'h6000;
      16:      t = 32'hD008;
      default: t = 32'h0110;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/reaction_timing_engine_if.sv
// Player/display-side bundle of the reaction timing engine. The game FSM and
// display decoders sit on the master side; the engine is the slave.
interface reaction_timing_engine_if #(
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned TARGETS = 8
);
  logic                  en;
  logic [TARGETS-1:0]    sw;
  logic [TARGETS-1:0]    target;
  logic [4*DIGITS-1:0]   time_bcd;
  logic [4*DIGITS-1:0]   score_bcd;
  logic [4*DIGITS-1:0]   best_bcd;
  logic [1:0]            state;
  logic                  hit;
  logic                  timeout;

  modport master (
    output en, sw,
    input  target, time_bcd, score_bcd, best_bcd, state, hit, timeout
  );

  modport slave (
    input  en, sw,
    output target, time_bcd, score_bcd, best_bcd, state, hit, timeout
  );
endinterface

// File: rtl/bcd_sync_counter.sv
// Fully synchronous saturating BCD counter. Digit k steps when inc is high and
// all lower digits are 9; the count holds at all nines instead of wrapping.
module bcd_sync_counter
  import reaction_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic                sat,
  output logic [4*DIGITS-1:0] q
);

  localparam logic [MaxW-1:0]     NinesFull = all_nines(DIGITS);
  localparam logic [4*DIGITS-1:0] Nines     = NinesFull[4*DIGITS-1:0];

  logic [4*DIGITS-1:0] q_d;
  logic                carry;

  assign sat = (q == Nines);

  // Carry chain across digits; clear wins over increment.
  always_comb begin
    q_d   = q;
    carry = inc & ~sat;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (carry) q_d[4*k +: 4] = (q[4*k +: 4] == 4'd9) ? 4'd0 : q[4*k +: 4] + 4'd1;
      carry = carry & (q[4*k +: 4] == 4'd9);
    end
    if (clr) q_d = '0;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= q_d;
  end

endmodule

// File: rtl/reaction_timing_engine.sv
// Reaction-timer measurement core: lights a random target LED on the en rise,
// counts ticks in BCD until sw matches, latches the score.
// Optional feature macro: BEST_SCORE_EN keeps the lowest hit score of the session.
module reaction_timing_engine
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1_000,
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned TARGETS = 8,
  parameter int unsigned LFSR_W  = 9
) (
  input logic                      clk,
  input logic                      rst,
  reaction_timing_engine_if.slave  bus
);

  localparam int unsigned Div    = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
  localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(Div - 1);

  localparam logic [MaxW-1:0]     NinesFull = all_nines(DIGITS);
  localparam logic [4*DIGITS-1:0] Nines     = NinesFull[4*DIGITS-1:0];
  localparam logic [31:0]         TapsFull  = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0]   Taps      = TapsFull[LFSR_W-1:0];
  localparam logic [TARGETS-1:0]  OneT      = {{(TARGETS-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic                en_q;
  logic [DivW-1:0]     div_q, div_d;
  logic                tick_en;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [LFSR_W-1:0]   tgt_idx;
  logic [TARGETS-1:0]  target_q, target_d;
  logic                seen_false_q, seen_false_d;
  logic [4*DIGITS-1:0] score_q, score_d;
  logic                hit_q, hit_d;
  logic                arm;
  logic                match;
  logic                sat;
  logic [4*DIGITS-1:0] time_q;

  assign tick_en = (state_q == StArmed) && (div_q == DivMax);
  assign match   = (bus.sw == target_q);
  assign tgt_idx = lfsr_q % LFSR_W'(TARGETS);

  bcd_sync_counter #(
    .DIGITS (DIGITS)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (arm),
    .inc (tick_en),
    .sat (sat),
    .q   (time_q)
  );

  // Tick divider: free-runs only while armed, otherwise parked at zero.
  always_comb begin
    div_d = '0;
    if (state_q == StArmed && !tick_en) div_d = div_q + 1'b1;
  end

  // Next state and round actions; in ARMED abort beats match beats timeout.
  // seen_false blocks a hit until sw has differed from the target once.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    seen_false_d = seen_false_q;
    score_d      = score_q;
    hit_d        = 1'b0;
    arm          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.en && !en_q) begin
          state_d      = StArmed;
          target_d     = OneT << tgt_idx;
          seen_false_d = 1'b0;
          arm          = 1'b1;
        end
      end
      StArmed: begin
        if (!bus.en) begin
          state_d = StIdle;
        end else if (match && seen_false_q) begin
          state_d = StHit;
          score_d = time_q;
          hit_d   = 1'b1;
        end else if (tick_en && sat) begin
          state_d = StTimeout;
          score_d = Nines;
        end else if (!match) begin
          seen_false_d = 1'b1;
        end
      end
      StHit, StTimeout: begin
        if (!bus.en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, edge detect, divider, LFSR and score registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      en_q         <= 1'b0;
      div_q        <= '0;
      lfsr_q       <= LFSR_W'(1);
      target_q     <= '0;
      seen_false_q <= 1'b0;
      score_q      <= '0;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= bus.en;
      div_q        <= div_d;
      lfsr_q       <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & Taps)};
      target_q     <= target_d;
      seen_false_q <= seen_false_d;
      score_q      <= score_d;
      hit_q        <= hit_d;
    end
  end

`ifdef BEST_SCORE_EN
  logic [4*DIGITS-1:0] best_q;

  // Session best: only hits compete, timeouts never do.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q <= Nines;
    end else if (hit_d && bcd_lt(MaxW'(time_q), MaxW'(best_q), DIGITS)) begin
      best_q <= time_q;
    end
  end

  assign bus.best_bcd = best_q;
`else
  assign bus.best_bcd = Nines;
`endif

  assign bus.target    = (state_q == StArmed) ? target_q : '0;
  assign bus.time_bcd  = time_q;
  assign bus.score_bcd = score_q;
  assign bus.state     = state_q;
  assign bus.hit       = hit_q;
  assign bus.timeout   = (state_q == StTimeout);

endmodule
